// File: rtl/ex_muldiv_unit_if.sv
// Handshake and result bundle between the EX stage and the iterative multiply/divide unit.
interface ex_muldiv_unit_if #(parameter int WIDTH = 32);
  logic             Start;
  logic             RdHiLo;
  logic [5:0]       Funct_EX;
  logic [WIDTH-1:0] RD1_EX;
  logic [WIDTH-1:0] RD2_EX;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             Busy;
  logic             Stall;
  logic             Done;
  logic             DivZero;

  modport master (
    output Start, RdHiLo, Funct_EX, RD1_EX, RD2_EX,
    input  HI, LO, Busy, Stall, Done, DivZero
  );

  modport slave (
    input  Start, RdHiLo, Funct_EX, RD1_EX, RD2_EX,
    output HI, LO, Busy, Stall, Done, DivZero
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and hazard stall request.
// Optional macro MULDIV_EARLY_OUT_EN: multiply finishes once the remaining multiplier bits are zero.
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic              Clk,
  input logic              Rst,
  ex_muldiv_unit_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    logic signed [WIDTH-1:0] sx;
    sx = x;
    return (sgn && sx < 0) ? -x : x;
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic               op_div;
  logic               neg_main;
  logic               neg_rem;
  logic               dz;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;
  logic               divzero_q;

  // Shared datapath: multiply uses acc/mcand/mplier; divide keeps the
  // remainder in acc[WIDTH-1:0], divisor in mcand[WIDTH-1:0], quotient in mplier.
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;

  logic is_mul, is_div, is_sgn, accept, wr_hi, wr_lo, busy, mul_last;
  logic [2*WIDTH-1:0] mul_acc;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_trial;
  logic [WIDTH-1:0]   div_rem;
  logic               div_qbit;
  logic [2*WIDTH-1:0] prod;

  assign is_mul = (bus.Funct_EX == F_MULT) || (bus.Funct_EX == F_MULTU);
  assign is_div = (bus.Funct_EX == F_DIV)  || (bus.Funct_EX == F_DIVU);
  assign is_sgn = (bus.Funct_EX == F_MULT) || (bus.Funct_EX == F_DIV);
  assign accept = bus.Start && (is_mul || is_div) && (state == ST_IDLE);
  assign wr_hi  = bus.Start && (bus.Funct_EX == F_MTHI) && (state == ST_IDLE);
  assign wr_lo  = bus.Start && (bus.Funct_EX == F_MTLO) && (state == ST_IDLE);
  assign busy   = (state != ST_IDLE);

  assign mul_acc = acc + (mplier[0] ? mcand : '0);

  // Restoring step: a negative trial difference means the divisor did not fit.
  always_comb begin
    div_shift = {acc[WIDTH-1:0], mplier[WIDTH-1]};
    div_trial = {1'b0, div_shift} - {2'b00, mcand[WIDTH-1:0]};
    div_qbit  = ~div_trial[WIDTH+1];
    div_rem   = div_qbit ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
  end

`ifdef MULDIV_EARLY_OUT_EN
  assign mul_last = ~op_div && (mplier[WIDTH-1:1] == '0);
`else
  assign mul_last = 1'b0;
`endif

  assign prod = neg_2w(acc, neg_main);

  always_ff @(posedge Clk) begin
    if (accept) begin
      acc <= '0;
      if (is_div) begin
        mplier <= mag(bus.RD1_EX, is_sgn);
        mcand  <= {{WIDTH{1'b0}}, mag(bus.RD2_EX, is_sgn)};
      end else begin
        mcand  <= {{WIDTH{1'b0}}, mag(bus.RD1_EX, is_sgn)};
        mplier <= mag(bus.RD2_EX, is_sgn);
      end
    end else if (state == ST_RUN) begin
      if (op_div) begin
        acc    <= {{WIDTH{1'b0}}, div_rem};
        mplier <= {mplier[WIDTH-2:0], div_qbit};
      end else begin
        acc    <= mul_acc;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      op_div    <= 1'b0;
      neg_main  <= 1'b0;
      neg_rem   <= 1'b0;
      dz        <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= ST_RUN;
            cnt      <= '0;
            op_div   <= is_div;
            neg_main <= is_sgn && (bus.RD1_EX[WIDTH-1] ^ bus.RD2_EX[WIDTH-1]);
            neg_rem  <= is_sgn && bus.RD1_EX[WIDTH-1];
            dz       <= is_div && (bus.RD2_EX == '0);
          end else if (wr_hi) begin
            hi_q <= bus.RD1_EX;
          end else if (wr_lo) begin
            lo_q <= bus.RD1_EX;
          end
        end
        ST_RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_STEP || mul_last) state <= ST_FIX;
        end
        ST_FIX: begin
          state     <= ST_IDLE;
          done_q    <= 1'b1;
          divzero_q <= dz;
          if (!op_div) begin
            hi_q <= prod[2*WIDTH-1:WIDTH];
            lo_q <= prod[WIDTH-1:0];
          end else if (!dz) begin
            lo_q <= neg_w(mplier, neg_main);
            hi_q <= neg_w(acc[WIDTH-1:0], neg_rem);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.HI      = hi_q;
  assign bus.LO      = lo_q;
  assign bus.Busy    = busy;
  assign bus.Stall   = busy && (bus.Start || bus.RdHiLo);
  assign bus.Done    = done_q;
  assign bus.DivZero = divzero_q;
endmodule
